// File: rtl/vram_write_arbiter.sv
// Single-port VRAM write arbiter: CPU writes are queued in a small FIFO, engine beats
// use req/gnt, and a burst limiter guarantees the CPU a slot during long engine runs.
module vram_write_arbiter #(
  parameter int          FIFO_DEPTH    = 4,
  parameter int          ENG_BURST_MAX = 8,
  parameter logic [15:0] IDLE_ADDR     = 16'h8000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cpu_wr_valid,
  input  logic [14:0]                   cpu_wr_addr,
  input  logic [7:0]                    cpu_wr_data,
  output logic                          cpu_wr_ready,
  output logic                          cpu_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          eng_req,
  input  logic [14:0]                   eng_addr,
  input  logic [7:0]                    eng_data,
  output logic                          eng_gnt,
  output logic [15:0]                   vram_write_address,
  output logic [7:0]                    vram_write_data
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int BW = $clog2(ENG_BURST_MAX + 1);

  typedef struct packed {
    logic [14:0] addr;
    logic [7:0]  data;
  } wr_beat_t;

  wr_beat_t        mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;
  logic [BW-1:0]   burst_cnt;

  logic full, cpu_pend, push, burst_max, eng_win, cpu_win;
  wr_beat_t head;

  assign full      = (level == LW'(FIFO_DEPTH));
  assign cpu_pend  = (level != '0);
  assign push      = cpu_wr_valid && !full;
  assign burst_max = (burst_cnt == BW'(ENG_BURST_MAX));
  // Engine has priority until it has used up its burst allowance against a waiting CPU.
  assign eng_win   = eng_req && !(cpu_pend && burst_max);
  assign cpu_win   = cpu_pend && !eng_win;
  assign head      = mem[rd_ptr];

  assign cpu_wr_ready = !full;
  assign eng_gnt      = eng_win;
  assign fifo_level   = level;

  // Storage needs no reset; level/pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: cpu_wr_addr, data: cpu_wr_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + PW'(1);
      if (cpu_win) rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(push) - LW'(cpu_win);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (cpu_win || !cpu_pend) begin
      burst_cnt <= '0;
    end else if (eng_win && !burst_max) begin
      burst_cnt <= burst_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cpu_overflow <= 1'b0;
    else if (cpu_wr_valid && full) cpu_overflow <= 1'b1;
  end

  // Registered write port; data holds when idle so only the address marks validity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vram_write_address <= IDLE_ADDR;
      vram_write_data    <= 8'h00;
    end else if (eng_win) begin
      vram_write_address <= {1'b0, eng_addr};
      vram_write_data    <= eng_data;
    end else if (cpu_win) begin
      vram_write_address <= {1'b0, head.addr};
      vram_write_data    <= head.data;
    end else begin
      vram_write_address <= IDLE_ADDR;
    end
  end

endmodule
